// File: rtl/exp_norm_pkg.sv
// Shared state encoding and exponent helpers for the FP add/sub normalizer.
package exp_norm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RSHIFT = 2'd1,
        ST_LSHIFT = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // All-ones exponent for a given width; callers cast to their own width.
    function automatic int unsigned EXP_MAX(input int unsigned ew);
        return (32'(1) << ew) - 32'(1);
    endfunction

endpackage

// File: rtl/exp_incdec.sv
// Combinational W-bit increment/decrement unit; co is carry on increment, borrow on decrement.
module exp_incdec #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a,
    input  logic         dec,
    output logic [W-1:0] y,
    output logic         co
);

    always_comb begin
        if (dec) begin
            {co, y} = {1'b0, a} - (W+1)'(1);
        end else begin
            {co, y} = {1'b0, a} + (W+1)'(1);
        end
    end

endmodule

// File: rtl/exp_normalizer.sv
// Iterative significand normalizer with exponent adjust and overflow/underflow/zero flags.
// Define STICKY_ROUND_EN to build the sticky register fed to the rounding stage.
module exp_normalizer
    import exp_norm_pkg::*;
#(
    parameter int unsigned EW = 8,
    parameter int unsigned SW = 23
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [EW-1:0] exp_i,
    input  logic [SW+1:0] sig_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [EW-1:0] exp_o,
    output logic [SW:0]   sig_o,
    output logic          overflow_o,
    output logic          underflow_o,
    output logic          zero_o,
    output logic          sticky_o
);

    localparam logic [EW-1:0] EMAX = EW'(EXP_MAX(EW));

    state_e        state;
    logic [EW-1:0] exp_q;
    logic [SW+1:0] sig_q;
    logic          ovf_q;
    logic          unf_q;
    logic          zero_q;
    logic [EW-1:0] exp_step;
    logic          exp_co;

    exp_incdec #(
        .W (EW)
    ) u_incdec (
        .a   (exp_q),
        .dec (state == ST_LSHIFT),
        .y   (exp_step),
        .co  (exp_co)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            exp_q  <= '0;
            sig_q  <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid_i) begin
                        exp_q  <= exp_i;
                        sig_q  <= sig_i;
                        ovf_q  <= 1'b0;
                        unf_q  <= 1'b0;
                        zero_q <= 1'b0;
                        if (sig_i == '0) begin
                            exp_q  <= '0;
                            zero_q <= 1'b1;
                            state  <= ST_DONE;
                        end else if (exp_i == EMAX) begin
                            ovf_q <= 1'b1;
                            sig_q <= '0;
                            state <= ST_DONE;
                        end else if (sig_i[SW+1]) begin
                            state <= ST_RSHIFT;
                        end else if (sig_i[SW]) begin
                            state <= ST_DONE;
                        end else begin
                            state <= ST_LSHIFT;
                        end
                    end
                end
                ST_RSHIFT: begin
                    exp_q <= exp_step;
                    if (exp_step == EMAX || exp_co) begin
                        ovf_q <= 1'b1;
                        sig_q <= '0;
                    end else begin
                        sig_q <= sig_q >> 1;
                    end
                    state <= ST_DONE;
                end
                ST_LSHIFT: begin
                    // Exponent cannot go below 1 as a normal: stop here as a denormal.
                    if (exp_q < EW'(2) && !sig_q[SW]) begin
                        unf_q <= 1'b1;
                        exp_q <= '0;
                        state <= ST_DONE;
                    end else begin
                        sig_q <= sig_q << 1;
                        exp_q <= exp_step;
                        if (sig_q[SW-1]) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready_i) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef STICKY_ROUND_EN
    logic sticky_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sticky_q <= 1'b0;
        end else if (state == ST_IDLE && in_valid_i) begin
            sticky_q <= 1'b0;
        end else if (state == ST_RSHIFT) begin
            sticky_q <= sig_q[0];
        end
    end

    assign sticky_o = sticky_q;
`else
    assign sticky_o = 1'b0;
`endif

    assign in_ready_o  = (state == ST_IDLE);
    assign out_valid_o = (state == ST_DONE);
    assign exp_o       = exp_q;
    assign sig_o       = sig_q[SW:0];
    assign overflow_o  = ovf_q;
    assign underflow_o = unf_q;
    assign zero_o      = zero_q;

endmodule

// File: tb/tb_exp_normalizer.sv
// Directed-vector bench for exp_normalizer (EW=8, SW=23) with hand-computed results.
module tb_exp_normalizer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  exp_in;
    logic [24:0] sig_in;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  exp_out;
    logic [23:0] sig_out;
    logic        ovf;
    logic        unf;
    logic        zero;
    logic        sticky;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef STICKY_ROUND_EN
    localparam logic STK = 1'b1;
`else
    localparam logic STK = 1'b0;
`endif

    exp_normalizer #(
        .EW (8),
        .SW (23)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .exp_i       (exp_in),
        .sig_i       (sig_in),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .exp_o       (exp_out),
        .sig_o       (sig_out),
        .overflow_o  (ovf),
        .underflow_o (unf),
        .zero_o      (zero),
        .sticky_o    (sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    // Issue one operand, measure accept-to-valid latency and check the result.
    task automatic run_op(input string tag, input logic [7:0] e, input logic [24:0] s,
                          input int lat, input logic [7:0] xe, input logic [23:0] xs,
                          input logic [3:0] xflags, input bit release_out);
        int cnt;
        cnt      = 0;
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        exp_in   = e;
        sig_in   = s;
        do begin
            @(posedge clk);
            #1;
            cnt++;
            in_valid = 1'b0;
        end while (!out_valid && cnt < 40);
        check({tag, " latency"}, 32'(cnt), 32'(lat));
        check({tag, " exp"}, 32'(exp_out), 32'(xe));
        check({tag, " sig"}, 32'(sig_out), 32'(xs));
        check({tag, " flags"}, 32'({ovf, unf, zero, sticky}), 32'(xflags));
        if (release_out) begin
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            check({tag, " back to idle"}, 32'({in_ready, out_valid}), 32'b10);
        end
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        exp_in    = '0;
        sig_in    = '0;
        #12;
        check("reset outputs", 32'({in_ready, out_valid, ovf, unf, zero, sticky}), 32'b100000);
        check("reset exp/sig", {exp_out, sig_out}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // flags = {overflow, underflow, zero, sticky}
        run_op("direct",     8'h7F, 25'h0800000, 1,  8'h7F, 24'h800000, 4'b0000, 1'b1);
        run_op("carry",      8'h80, 25'h1800000, 2,  8'h81, 24'hC00000, 4'b0000, 1'b1);
        run_op("carry stk",  8'h80, 25'h1800001, 2,  8'h81, 24'hC00000, {3'b000, STK}, 1'b1);
        run_op("carry clr",  8'h80, 25'h1800000, 2,  8'h81, 24'hC00000, 4'b0000, 1'b1);
        run_op("ovf rshift", 8'hFE, 25'h1000000, 2,  8'hFF, 24'h000000, 4'b1000, 1'b1);
        run_op("ovf input",  8'hFF, 25'h0800000, 1,  8'hFF, 24'h000000, 4'b1000, 1'b1);
        run_op("lshift 13",  8'h10, 25'h0000400, 14, 8'h03, 24'h800000, 4'b0000, 1'b1);
        run_op("lshift 1",   8'h03, 25'h0400000, 2,  8'h02, 24'h800000, 4'b0000, 1'b1);
        run_op("underflow",  8'h02, 25'h0100000, 3,  8'h00, 24'h200000, 4'b0100, 1'b1);
        run_op("unf exp1",   8'h01, 25'h0400000, 2,  8'h00, 24'h400000, 4'b0100, 1'b1);
        run_op("zero",       8'h55, 25'h0000000, 1,  8'h00, 24'h000000, 4'b0010, 1'b1);

        // Backpressure: result must hold and new operands must be ignored.
        run_op("bp", 8'h7F, 25'h0800000, 1, 8'h7F, 24'h800000, 4'b0000, 1'b0);
        in_valid = 1'b1;
        exp_in   = 8'h20;
        sig_in   = 25'h0000001;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp hold ctrl", 32'({in_ready, out_valid}), 32'b01);
            check("bp hold data", {exp_out, sig_out}, {8'h7F, 24'h800000});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp release", 32'({in_ready, out_valid}), 32'b10);

        // Reset in the middle of a left-shift sequence.
        in_valid = 1'b1;
        exp_in   = 8'h10;
        sig_in   = 25'h0000400;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("rst mid ctrl", 32'({in_ready, out_valid, ovf, unf, zero, sticky}), 32'b100000);
        check("rst mid data", {exp_out, sig_out}, 32'd0);
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;
        run_op("after rst", 8'h80, 25'h1800000, 2, 8'h81, 24'hC00000, 4'b0000, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
